flash_read_arbiter: RTL and testbench

Burst controller and two-port round-robin arbiter placed in front of the single-byte SPI flash reader, which takes a one-cycle `read` pulse with `addr` and returns a one-cycle `ready` pulse with `data`. Each requester, for example the UART command path or a boot/config loader, asks for a burst of consecutive bytes. The block sequences one flash read per byte, hands each byte back under a valid/ack handshake and reports completion or timeout. The flash reader is never issued a new read while one is outstanding.

---
 rtl/flash_read_arbiter.sv | 150 +++++++++++++++
 tb/tb_flash_read_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_read_arbiter.sv
// Two-port round-robin burst arbiter in front of a single-byte SPI flash reader.
// Issues one read per byte, never more than one outstanding, with per-read timeout.
module flash_read_arbiter #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0,
  input  logic             req1,
  input  logic [23:0]      addr0,
  input  logic [23:0]      addr1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [7:0]       rd_data,
  output logic             rd_valid0,
  output logic             rd_valid1,
  input  logic             rd_ack0,
  input  logic             rd_ack1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic             fl_read,
  output logic [23:0]      fl_addr,
  input  logic             fl_ready,
  input  logic [7:0]       fl_data,
  output logic             busy
);

  // The wait counter only has to reach TIMEOUT-1 before the abort decision.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               abort_q, abort_d;
  logic [23:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;

  logic               win;
  logic [LEN_W-1:0]   winLen;
  logic               ackOwn;

  assign ackOwn = owner_q ? rd_ack1 : rd_ack0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      abort_q  <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      abort_q  <= abort_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    abort_d  = abort_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    // On a tie the requester that did not win last time takes the bus.
    win      = (req0 && req1) ? ~last_q : req1;
    winLen   = win ? len1 : len0;

    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d  = win;
          addr_d   = win ? addr1 : addr0;
          remain_d = winLen;
          state_d  = (winLen == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fl_ready) begin
          data_d  = fl_data;
          state_d = ST_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          abort_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (ackOwn) begin
          if (remain_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            remain_d = remain_q - 1'b1;
            addr_d   = addr_q + 24'd1;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        last_d  = owner_q;
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign gnt0      = busy && !owner_q;
  assign gnt1      = busy && owner_q;
  assign fl_read   = (state_q == ST_ISSUE);
  assign fl_addr   = addr_q;
  assign rd_data   = data_q;
  assign rd_valid0 = (state_q == ST_HOLD) && !owner_q;
  assign rd_valid1 = (state_q == ST_HOLD) && owner_q;
  assign done0     = (state_q == ST_DONE) && !owner_q;
  assign done1     = (state_q == ST_DONE) && owner_q;
  assign err       = (state_q == ST_DONE) && abort_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: burst table, scoreboard of
// expected read addresses and bytes, and hand-written corner sequences.
module tb_flash_read_arbiter;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req0, req1;
  logic [23:0]      addr0, addr1;
  logic [LEN_W-1:0] len0, len1;
  logic             gnt0, gnt1;
  logic [7:0]       rd_data;
  logic             rd_valid0, rd_valid1;
  logic             rd_ack0, rd_ack1;
  logic             done0, done1, err;
  logic             fl_read;
  logic [23:0]      fl_addr;
  wire              fl_ready;
  wire  [7:0]       fl_data;
  logic             busy;

  logic             modelReady = 1'b0;
  logic [7:0]       modelData = 8'h00;
  int               pendCnt = 0;
  logic [23:0]      pendAddr = '0;
  int               flLatency = 5;
  logic             flEnable = 1'b1;
  logic             forceReady = 1'b0;

  int               nCompared = 0;
  int               nFail = 0;
  logic             lastHs = 1'b0;
  logic [23:0]      expAddrQ[$];
  logic [8:0]       expDataQ[$];

  typedef struct {
    logic        port;
    logic [23:0] addr;
    int          len;
    int          expReads;
    int          expBytes;
  } burst_t;

  burst_t vecs[5];

  assign fl_ready = modelReady | forceReady;
  assign fl_data  = modelData;

  always #5 clk = ~clk;

  flash_read_arbiter #(.LEN_W(LEN_W), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .len0(len0), .len1(len1), .gnt0(gnt0), .gnt1(gnt1),
    .rd_data(rd_data), .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
    .rd_ack0(rd_ack0), .rd_ack1(rd_ack1), .done0(done0), .done1(done1),
    .err(err), .fl_read(fl_read), .fl_addr(fl_addr),
    .fl_ready(fl_ready), .fl_data(fl_data), .busy(busy)
  );

  function automatic logic [7:0] memByte(input logic [23:0] a);
    case (a)
      24'h400000: return 8'hA5;
      24'h400001: return 8'h5A;
      24'h400002: return 8'hFF;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endcase
  endfunction

  // Flash reader: answers each strobe after flLatency cycles unless disabled.
  always @(negedge clk) begin
    if (!rstn) begin
      pendCnt    <= 0;
      modelReady <= 1'b0;
    end else begin
      modelReady <= 1'b0;
      if (pendCnt == 1) begin
        modelReady <= 1'b1;
        modelData  <= memByte(pendAddr);
      end
      if (pendCnt > 0) pendCnt <= pendCnt - 1;
      if (fl_read && flEnable) begin
        pendCnt  <= flLatency;
        pendAddr <= fl_addr;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name, input logic [31:0] act);
    nCompared++;
    nFail++;
    $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  // Advance one clock; handshakes are judged on pre-edge values, reads after it.
  task automatic cycle();
    logic hs0, hs1;
    logic [7:0] d;
    logic [8:0] expD;
    logic [23:0] expA;
    hs0 = rd_valid0 && rd_ack0;
    hs1 = rd_valid1 && rd_ack1;
    d   = rd_data;
    @(posedge clk);
    #1;
    lastHs = hs0 || hs1;
    if (hs0 || hs1) begin
      if (expDataQ.size() == 0) begin
        reportFail("unexpected byte", 32'({hs1, d}));
      end else begin
        expD = expDataQ.pop_front();
        checkOutput("byte owner/data", 32'({hs1, d}), 32'(expD));
      end
    end
    if (fl_read) begin
      checkOutput("read while outstanding", 32'(pendCnt != 0), 32'd0);
      if (expAddrQ.size() == 0) begin
        reportFail("unexpected fl_read", 32'(fl_addr));
      end else begin
        expA = expAddrQ.pop_front();
        checkOutput("fl_addr", 32'(fl_addr), 32'(expA));
      end
    end
  endtask

  task automatic pushExpect(input logic port, input logic [23:0] addr, input int n, input logic withData);
    logic [23:0] a;
    for (int i = 0; i < n; i++) begin
      a = addr + 24'(i);
      expAddrQ.push_back(a);
      if (withData) expDataQ.push_back({port, memByte(a)});
    end
  endtask

  task automatic resetDut();
    req0 = 1'b0;
    req1 = 1'b0;
    expAddrQ.delete();
    expDataQ.delete();
    rstn = 1'b0;
    #1;
    checkOutput("reset outputs", 32'({gnt0, gnt1, rd_valid0, rd_valid1, done0, done1, err, fl_read, busy}), 32'd0);
    checkOutput("reset fl_addr", 32'(fl_addr), 32'd0);
    checkOutput("reset rd_data", 32'(rd_data), 32'd0);
    cycle();
    cycle();
    rstn = 1'b1;
    cycle();
  endtask

  task automatic applyStimulus(input logic port, input logic [23:0] addr, input int len,
                               input int expReads, input int expBytes);
    int reads, bytesSeen, k, lastRead;
    logic otherSeen, gotDone;
    pushExpect(port, addr, len, 1'b1);
    if (port) begin
      req1 = 1'b1; addr1 = addr; len1 = LEN_W'(len);
    end else begin
      req0 = 1'b1; addr0 = addr; len0 = LEN_W'(len);
    end
    cycle();
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("grant owner", 32'({gnt1, gnt0}), port ? 32'd2 : 32'd1);
    checkOutput("busy in burst", 32'(busy), 32'd1);
    reads = 0; bytesSeen = 0; k = 0; lastRead = -1; otherSeen = 1'b0; gotDone = 1'b0;
    while (1) begin
      if (fl_read) begin
        if (lastRead >= 0) checkOutput("read spacing", 32'(k - lastRead), 32'(flLatency + 2));
        lastRead = k;
        reads++;
      end
      otherSeen = otherSeen | (port ? (rd_valid0 | done0 | gnt0) : (rd_valid1 | done1 | gnt1));
      gotDone = port ? done1 : done0;
      if (gotDone || k >= 300) break;
      cycle();
      k++;
      bytesSeen += int'(lastHs);
    end
    if (!gotDone) begin
      reportFail("burst done wait", 32'(k));
    end else begin
      checkOutput("burst err", 32'(err), 32'd0);
      checkOutput("burst read count", 32'(reads), 32'(expReads));
      checkOutput("burst byte count", 32'(bytesSeen), 32'(expBytes));
      checkOutput("other port quiet", 32'(otherSeen), 32'd0);
    end
    cycle();
    checkOutput("idle after done", 32'({busy, gnt0, gnt1, done0, done1}), 32'd0);
  endtask

  initial begin
    int k, grants, cyc, doneCyc;
    logic expPort, prevGnt, stallBad;
    logic [7:0] held;

    vecs[0] = '{1'b0, 24'h400000, 3, 3, 3};
    vecs[1] = '{1'b1, 24'hFFFFFE, 3, 3, 3};
    vecs[2] = '{1'b0, 24'h000010, 0, 0, 0};
    vecs[3] = '{1'b1, 24'h123456, 2, 2, 2};
    vecs[4] = '{1'b0, 24'hABCDEF, 1, 1, 1};

    rstn = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    rd_ack0 = 1'b1; rd_ack1 = 1'b1;
    #3;
    resetDut();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].port, vecs[i].addr, vecs[i].len, vecs[i].expReads, vecs[i].expBytes);
      checkOutput("queues drained", 32'(expAddrQ.size() + expDataQ.size()), 32'd0);
    end

    // Back-pressure: second byte is left unacknowledged for 20 cycles.
    rd_ack0 = 1'b0;
    pushExpect(1'b0, 24'h000300, 3, 1'b1);
    req0 = 1'b1; addr0 = 24'h000300; len0 = 8'd3;
    cycle();
    req0 = 1'b0;
    for (int b = 0; b < 3; b++) begin
      k = 0;
      while (!rd_valid0 && k < 50) begin cycle(); k++; end
      if (!rd_valid0) reportFail("stall byte wait", 32'(b));
      if (b == 1) begin
        held = rd_data;
        stallBad = 1'b0;
        for (int s = 0; s < 20; s++) begin
          cycle();
          stallBad = stallBad | (rd_data != held) | fl_read | !rd_valid0;
        end
        checkOutput("stall stable", 32'(stallBad), 32'd0);
      end
      rd_ack0 = 1'b1;
      cycle();
      rd_ack0 = 1'b0;
      checkOutput("valid drops after ack", 32'(rd_valid0), 32'd0);
      if (b < 2) checkOutput("read after ack", 32'(fl_read), 32'd1);
      else       checkOutput("done after last ack", 32'(done0), 32'd1);
    end
    rd_ack0 = 1'b1;
    cycle();
    checkOutput("stall queues drained", 32'(expAddrQ.size() + expDataQ.size()), 32'd0);

    // Tie and alternation from reset: grants must go 0,1,0,1.
    resetDut();
    for (int r = 0; r < 2; r++) begin
      pushExpect(1'b0, 24'h000100, 1, 1'b1);
      pushExpect(1'b1, 24'h000200, 1, 1'b1);
    end
    addr0 = 24'h000100; addr1 = 24'h000200; len0 = 8'd1; len1 = 8'd1;
    req0 = 1'b1; req1 = 1'b1;
    grants = 0; cyc = 0; doneCyc = -100; expPort = 1'b0; prevGnt = 1'b0;
    while (grants < 4 && cyc < 200) begin
      cycle();
      cyc++;
      if ((gnt0 | gnt1) && !prevGnt) begin
        checkOutput("tie grant order", 32'({gnt1, gnt0}), expPort ? 32'd2 : 32'd1);
        if (grants > 0) checkOutput("done to next grant", 32'(cyc - doneCyc), 32'd2);
        expPort = ~expPort;
        grants++;
        if (grants == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (done0 | done1) doneCyc = cyc;
      prevGnt = gnt0 | gnt1;
    end
    if (grants < 4) reportFail("tie grant wait", 32'(grants));
    k = 0;
    while (busy && k < 50) begin cycle(); k++; end
    checkOutput("tie queues drained", 32'(expAddrQ.size() + expDataQ.size()), 32'd0);

    // Timeout: reader stays silent, done0+err exactly 17 cycles after fl_read.
    flEnable = 1'b0;
    pushExpect(1'b0, 24'h000700, 1, 1'b0);
    req0 = 1'b1; addr0 = 24'h000700; len0 = 8'd2;
    cycle();
    req0 = 1'b0;
    checkOutput("timeout read issued", 32'(fl_read), 32'd1);
    k = 0;
    while (!done0 && k < 100) begin cycle(); k++; end
    checkOutput("timeout delay", 32'(k), 32'd17);
    checkOutput("timeout err with done", 32'(err), 32'd1);
    cycle();
    checkOutput("idle after timeout", 32'({busy, err, done0}), 32'd0);
    forceReady = 1'b1;
    cycle();
    forceReady = 1'b0;
    checkOutput("late ready ignored", 32'({rd_valid0, rd_valid1, busy}), 32'd0);
    cycle();
    checkOutput("late ready still idle", 32'({rd_valid0, rd_valid1, busy, fl_read}), 32'd0);
    checkOutput("timeout queue drained", 32'(expAddrQ.size()), 32'd0);
    flEnable = 1'b1;

    // Reset while waiting on the first byte of a 4-byte burst.
    pushExpect(1'b0, 24'h000500, 1, 1'b0);
    req0 = 1'b1; addr0 = 24'h000500; len0 = 8'd4;
    cycle();
    req0 = 1'b0;
    cycle();
    cycle();
    checkOutput("waiting before reset", 32'({busy, gnt0, fl_addr}), 32'({2'b11, 24'h000500}));
    checkOutput("reset queue drained", 32'(expAddrQ.size()), 32'd0);
    resetDut();
    applyStimulus(1'b1, 24'h000600, 2, 2, 2);
    pushExpect(1'b0, 24'h000800, 1, 1'b1);
    addr0 = 24'h000800; addr1 = 24'h000900; len0 = 8'd1; len1 = 8'd1;
    req0 = 1'b1; req1 = 1'b1;
    cycle();
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("tie after reset", 32'({gnt1, gnt0}), 32'd1);
    k = 0;
    while (!done0 && k < 50) begin cycle(); k++; end
    if (!done0) reportFail("post-reset done wait", 32'(k));
    cycle();
    checkOutput("final queues drained", 32'(expAddrQ.size() + expDataQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
